// File: rtl/rr_fifo_sched_pkg.sv
// Shared sizing helpers for the merge schedulers: source-index width and burst-counter width.
package rr_fifo_sched_pkg;

   // A single source still gets a 1-bit index so ports never collapse to zero width.
   function automatic int src_w(input int num_src);
      return (num_src <= 1) ? 1 : $clog2(num_src);
   endfunction

   function automatic int burst_cnt_w(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requester at or above ptr, else lowest overall.
module rr_arbiter #(
   parameter int NUM_SRC = 4,
   parameter int SRC_W   = 2
) (
   input  logic [NUM_SRC-1:0] req_i,
   input  logic [SRC_W-1:0]   ptr_i,
   output logic [NUM_SRC-1:0] gnt_o,
   output logic [SRC_W-1:0]   idx_o,
   output logic               any_o
);
   logic [NUM_SRC-1:0] upper_mask;
   logic [NUM_SRC-1:0] upper_req;
   logic [NUM_SRC-1:0] search_req;

   always_comb begin
      upper_mask = ~((NUM_SRC'(1) << ptr_i) - NUM_SRC'(1));
      upper_req  = req_i & upper_mask;
      // Second pass only matters when nothing at or above ptr is requesting (the wrap case).
      search_req = (|upper_req) ? upper_req : req_i;
      gnt_o      = '0;
      idx_o      = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (search_req[i]) begin
            gnt_o    = '0;
            gnt_o[i] = 1'b1;
            idx_o    = SRC_W'(i);
         end
      end
      any_o = |req_i;
   end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a first-word-fall-through head and optional empty-FIFO bypass.
module sync_fifo #(
   parameter int DATA_WIDTH      = 32,
   parameter int DEPTH           = 4,
   parameter int FIFO_BYP_ENABLE = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] pop_data_o,
   output logic                  full_o,
   output logic                  empty_o
);
   localparam int  PTR_W = (DEPTH <= 1) ? 1 : $clog2(DEPTH);
   localparam int  CNT_W = $clog2(DEPTH + 1);
   localparam bit  BYP   = (FIFO_BYP_ENABLE != 0);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  is_empty, push_fire, pop_fire, through, wr_en, rd_en;

   assign is_empty   = (count_q == '0);
   assign full_o     = (count_q == CNT_W'(DEPTH));
   assign empty_o    = is_empty & ~(BYP & push_i);
   assign pop_data_o = (BYP && is_empty) ? push_data_i : mem_q[rd_ptr_q];

   // A full FIFO refuses a push even when it is popped in the same cycle.
   assign push_fire = push_i & ~full_o;
   assign pop_fire  = pop_i & ~empty_o;
   assign through   = BYP & is_empty & push_fire & pop_fire;
   assign wr_en     = push_fire & ~through;
   assign rd_en     = pop_fire & ~through;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en)
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (rd_en)
         rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      if (wr_en && !rd_en)
         count_d = count_q + CNT_W'(1);
      else if (rd_en && !wr_en)
         count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/rr_fifo_sched.sv
// Merges NUM_SRC buffered flit streams onto one registered valid/ready link with weighted round-robin.
module rr_fifo_sched
   import rr_fifo_sched_pkg::*;
#(
   parameter int  NUM_SRC    = 4,
   parameter int  DATA_WIDTH = 32,
   parameter int  FIFO_DEPTH = 4,
   parameter int  MAX_BURST  = 2,
   localparam int SRC_W      = src_w(NUM_SRC)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_SRC-1:0]            in_valid_i,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] in_data_i,
   output logic [NUM_SRC-1:0]            in_ready_o,
   output logic                          out_valid_o,
   output logic [DATA_WIDTH-1:0]         out_data_o,
   output logic [SRC_W-1:0]              out_src_id_o,
   input  logic                          out_ready_i
);
   localparam int CNT_W = burst_cnt_w(MAX_BURST);

   logic [NUM_SRC-1:0]    fifo_empty, fifo_full, req, gnt, pop;
   logic [DATA_WIDTH-1:0] head [NUM_SRC];
   logic [SRC_W-1:0]      gnt_idx;
   logic                  gnt_any, ld, grant;
   logic [CNT_W-1:0]      next_burst;

   logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [SRC_W-1:0]      out_src_id_q, out_src_id_d;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
         sync_fifo #(
            .DATA_WIDTH      (DATA_WIDTH),
            .DEPTH           (FIFO_DEPTH),
            .FIFO_BYP_ENABLE (0)
         ) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .push_i      (in_valid_i[gi]),
            .push_data_i (in_data_i[gi*DATA_WIDTH +: DATA_WIDTH]),
            .pop_i       (pop[gi]),
            .pop_data_o  (head[gi]),
            .full_o      (fifo_full[gi]),
            .empty_o     (fifo_empty[gi])
         );
      end
   endgenerate

   assign in_ready_o = ~fifo_full;
   assign req        = ~fifo_empty;

   rr_arbiter #(
      .NUM_SRC (NUM_SRC),
      .SRC_W   (SRC_W)
   ) u_arb (
      .req_i (req),
      .ptr_i (rr_ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx),
      .any_o (gnt_any)
   );

   // The output register can take a new flit when empty or being drained this cycle.
   assign ld    = ~out_valid_q | out_ready_i;
   assign grant = ld & gnt_any;
   assign pop   = grant ? gnt : '0;

   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      burst_cnt_d  = burst_cnt_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_src_id_d = out_src_id_q;
      next_burst   = (gnt_idx == rr_ptr_q) ? burst_cnt_q + CNT_W'(1) : CNT_W'(1);
      if (grant) begin
         out_valid_d  = 1'b1;
         out_data_d   = head[gnt_idx];
         out_src_id_d = gnt_idx;
         if (next_burst == CNT_W'(MAX_BURST)) begin
            rr_ptr_d    = (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + SRC_W'(1);
            burst_cnt_d = '0;
         end else begin
            rr_ptr_d    = gnt_idx;
            burst_cnt_d = next_burst;
         end
      end else if (out_ready_i) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q     <= '0;
         burst_cnt_q  <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_src_id_q <= '0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         burst_cnt_q  <= burst_cnt_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_src_id_q <= out_src_id_d;
      end
   end

   assign out_valid_o  = out_valid_q;
   assign out_data_o   = out_data_q;
   assign out_src_id_o = out_src_id_q;

endmodule

// File: tb/tb_rr_fifo_sched.sv
// Bench for rr_fifo_sched: directed scenarios, a vector table and a queue-based reference model.
module tb_rr_fifo_sched;
   localparam int N     = 4;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int MB    = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  in_valid_i = '0;
   logic [N*DW-1:0] in_data_i = '0;
   logic [N-1:0]  in_ready_o;
   logic          out_valid_o;
   logic [DW-1:0] out_data_o;
   logic [1:0]    out_src_id_o;
   logic          out_ready_i = 1'b0;

   always #5 clk = ~clk;

   rr_fifo_sched #(
      .NUM_SRC    (N),
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (DEPTH),
      .MAX_BURST  (MB)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid_i   (in_valid_i),
      .in_data_i    (in_data_i),
      .in_ready_o   (in_ready_o),
      .out_valid_o  (out_valid_o),
      .out_data_o   (out_data_o),
      .out_src_id_o (out_src_id_o),
      .out_ready_i  (out_ready_i)
   );

   int checks = 0;
   int errors = 0;
   bit verbose = 1'b1;

   // Reference model: per-source queues plus the scheduler's pointer and burst count.
   logic [DW-1:0] mq [N][$];
   bit            m_ov;
   logic [DW-1:0] m_od;
   int            m_os, m_ptr, m_cnt;

   int            acc_src[$];
   logic [DW-1:0] acc_data[$];

   typedef struct {
      logic          rdy;
      logic          ev;
      logic [1:0]    es;
      logic [DW-1:0] ed;
   } vec_t;
   vec_t tbl[$];

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic void model_reset();
      for (int s = 0; s < N; s++) mq[s].delete();
      m_ov = 1'b0; m_od = '0; m_os = 0; m_ptr = 0; m_cnt = 0;
   endfunction

   function automatic void model_step(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic rdy);
      bit acc [N];
      int g, nb;
      for (int s = 0; s < N; s++) acc[s] = v[s] && (mq[s].size() < DEPTH);
      g = -1;
      for (int k = 0; k < N; k++) begin
         int s;
         s = (m_ptr + k) % N;
         if (g < 0 && mq[s].size() > 0) g = s;
      end
      if (!m_ov || rdy) begin
         if (g >= 0) begin
            m_od = mq[g].pop_front();
            m_ov = 1'b1;
            m_os = g;
            nb   = (g == m_ptr) ? m_cnt + 1 : 1;
            if (nb == MB) begin
               m_ptr = (g + 1) % N; m_cnt = 0;
            end else begin
               m_ptr = g; m_cnt = nb;
            end
         end else begin
            m_ov = 1'b0;
         end
      end
      for (int s = 0; s < N; s++)
         if (acc[s]) mq[s].push_back(d[s*DW +: DW]);
   endfunction

   function automatic void compare_model();
      logic [N-1:0] exp_rdy;
      logic [38:0]  act, exp;
      for (int s = 0; s < N; s++) exp_rdy[s] = (mq[s].size() < DEPTH);
      act = {out_valid_o, in_ready_o, out_valid_o ? out_src_id_o : 2'b0, out_valid_o ? out_data_o : 32'h0};
      exp = {m_ov, exp_rdy, m_ov ? 2'(m_os) : 2'b0, m_ov ? m_od : 32'h0};
      chk("model{valid,ready,src,data}", 64'(act), 64'(exp));
   endfunction

   task automatic cycle();
      if (out_valid_o && out_ready_i) begin
         acc_src.push_back(int'(out_src_id_o));
         acc_data.push_back(out_data_o);
         if (verbose) $display("xfer src=%0d data=%08h t=%0t", out_src_id_o, out_data_o, $time);
      end
      @(posedge clk);
      if (rst) model_reset();
      else     model_step(in_valid_i, in_data_i, out_ready_i);
      #1;
      compare_model();
   endtask

   task automatic set_push(input int s, input logic [DW-1:0] d);
      in_valid_i[s]         = 1'b1;
      in_data_i[s*DW +: DW] = d;
   endtask

   task automatic do_reset();
      in_valid_i  = '0;
      out_ready_i = 1'b0;
      rst = 1'b1;
      model_reset();
      cycle();
      cycle();
      rst = 1'b0;
      acc_src.delete();
      acc_data.delete();
   endtask

   initial begin
      int pushes;
      vec_t v;
      int exp5 [6];

      // Reset values
      do_reset();
      chk("rst_out_valid", 64'(out_valid_o), 64'd0);
      chk("rst_out_data", 64'(out_data_o), 64'd0);
      chk("rst_out_src", 64'(out_src_id_o), 64'd0);
      chk("rst_in_ready", 64'(in_ready_o), 64'hF);

      // Single flit latency
      set_push(0, 32'hA0);
      cycle();
      in_valid_i = '0;
      chk("t1_valid_cyc2", 64'(out_valid_o), 64'd0);
      cycle();
      chk("t1_valid_cyc3", 64'(out_valid_o), 64'd1);
      chk("t1_data", 64'(out_data_o), 64'hA0);
      chk("t1_src", 64'(out_src_id_o), 64'd0);
      out_ready_i = 1'b1;
      cycle();
      chk("t1_drained", 64'(out_valid_o), 64'd0);

      // Burst order and output hold, driven from a vector table
      tbl.push_back('{1'b1, 1'b1, 2'd0, 32'h001});
      tbl.push_back('{1'b1, 1'b1, 2'd1, 32'h100});
      for (int i = 0; i < 5; i++) tbl.push_back('{1'b0, 1'b1, 2'd1, 32'h100});
      tbl.push_back('{1'b1, 1'b1, 2'd1, 32'h101});
      tbl.push_back('{1'b1, 1'b1, 2'd2, 32'h200});
      tbl.push_back('{1'b1, 1'b1, 2'd2, 32'h201});
      tbl.push_back('{1'b1, 1'b1, 2'd3, 32'h300});
      tbl.push_back('{1'b1, 1'b1, 2'd3, 32'h301});
      tbl.push_back('{1'b1, 1'b1, 2'd0, 32'h002});
      tbl.push_back('{1'b1, 1'b1, 2'd1, 32'h102});
      tbl.push_back('{1'b1, 1'b1, 2'd2, 32'h202});
      tbl.push_back('{1'b1, 1'b1, 2'd3, 32'h302});
      tbl.push_back('{1'b1, 1'b0, 2'd0, 32'h0});

      do_reset();
      for (int sq = 0; sq < 3; sq++) begin
         for (int s = 0; s < N; s++) set_push(s, DW'(s * 256 + sq));
         cycle();
      end
      in_valid_i = '0;
      chk("t2_first_src", 64'(out_src_id_o), 64'd0);
      chk("t2_first_data", 64'(out_data_o), 64'h000);
      for (int r = 0; r < tbl.size(); r++) begin
         v = tbl[r];
         out_ready_i = v.rdy;
         cycle();
         chk($sformatf("tbl%0d_valid", r), 64'(out_valid_o), 64'(v.ev));
         if (v.ev) begin
            chk($sformatf("tbl%0d_src", r), 64'(out_src_id_o), 64'(v.es));
            chk($sformatf("tbl%0d_data", r), 64'(out_data_o), 64'(v.ed));
         end
      end

      // Full FIFO refuses pushes; one drain reopens it
      do_reset();
      pushes = 0;
      while (in_ready_o[2] && pushes < 10) begin
         set_push(2, DW'(32'h2000 + pushes));
         cycle();
         pushes++;
      end
      chk("t3_fill_count", 64'(pushes), 64'(DEPTH + 1));
      chk("t3_full", 64'(in_ready_o[2]), 64'd0);
      set_push(2, 32'hDEAD);
      cycle();
      in_valid_i = '0;
      chk("t3_still_full", 64'(in_ready_o[2]), 64'd0);
      out_ready_i = 1'b1;
      cycle();
      chk("t3_ready_after_drain", 64'(in_ready_o[2]), 64'd1);
      repeat (8) cycle();
      chk("t3_xfer_count", 64'(acc_data.size()), 64'(DEPTH + 1));
      if (acc_data.size() > 0)
         chk("t3_last_data", 64'(acc_data[acc_data.size()-1]), 64'h2004);

      // Short source forfeits its burst, long source then bursts
      do_reset();
      out_ready_i = 1'b1;
      set_push(0, 32'h010);
      cycle();
      set_push(0, 32'h011); set_push(3, 32'h030);
      cycle();
      in_valid_i = '0;
      set_push(1, 32'h020); set_push(3, 32'h031);
      cycle();
      in_valid_i = '0;
      set_push(3, 32'h032);
      cycle();
      in_valid_i = '0;
      repeat (6) cycle();
      exp5 = '{0, 0, 1, 3, 3, 3};
      chk("t5_xfer_count", 64'(acc_src.size()), 64'd6);
      for (int i = 0; i < 6 && i < acc_src.size(); i++)
         chk($sformatf("t5_order%0d", i), 64'(acc_src[i]), 64'(exp5[i]));

      // Asynchronous reset mid-operation
      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_push(1, DW'(32'h600 + i));
         cycle();
      end
      in_valid_i = '0;
      cycle();
      chk("t6_pre_valid", 64'(out_valid_o), 64'd1);
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      chk("t6_valid_now", 64'(out_valid_o), 64'd0);
      chk("t6_ready_now", 64'(in_ready_o), 64'hF);
      chk("t6_data_now", 64'(out_data_o), 64'd0);
      cycle();
      rst = 1'b0;
      out_ready_i = 1'b1;
      acc_src.delete();
      repeat (5) cycle();
      chk("t6_no_stale", 64'(acc_src.size()), 64'd0);
      chk("t6_valid_after", 64'(out_valid_o), 64'd0);

      // Randomized traffic against the reference model
      do_reset();
      verbose = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         in_valid_i = N'($urandom);
         for (int s = 0; s < N; s++) in_data_i[s*DW +: DW] = $urandom;
         out_ready_i = ($urandom_range(0, 3) != 0);
         cycle();
      end
      in_valid_i  = '0;
      out_ready_i = 1'b1;
      repeat (20) cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

endmodule
